imem_pipe: RTL

- Parametrised, pipelined instruction memory for the MIPS fetch stage.
- Word-addressed storage is indexed by byte address >> 2.
- Read latency is configurable, with a valid/ready request and response handshake so fetch can stall.
- Adds a program-load write port and reports fault flags for misaligned and out-of-range fetches.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_array.sv | 39 +++
 rtl/imem_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction-memory pipeline.
//   FAULT_MISALIGN / FAULT_RANGE : bit positions within the 2-bit fault field
//   IDX_W                        : stored word-index width (byte addr >> 2, ADDR_W up to 32)
//   DEFAULT_NOP_WORD             : instruction substituted on a faulting fetch
//   fetch_stage_t                : per-stage pipeline slot {valid, index, fault}
package imem_pkg;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam int IDX_W = 30;

    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic [1:0]       fault;
    } fetch_stage_t;

endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word storage, one write port and one registered
// read port. A read and a write to the same word in the same cycle return the
// new data (write-first). Storage itself is never reset; only the read
// register is, so the pipeline output comes up as zero.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port, caller guarantees waddr < DEPTH
//   re/raddr       : read enable/address, caller guarantees raddr < DEPTH
//   rdata          : registered read data, held while re=0
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Holding rdata when re=0 lets a stalled pipeline keep its stage-1 word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/imem_pipe.sv
// imem_pipe: pipelined instruction memory for the fetch stage.
// A request is accepted on req_valid & req_ready; its response appears LAT
// cycles later on rsp_*. The whole pipe freezes while a response is offered
// but not taken. Misaligned or out-of-range fetches return NOP_WORD with the
// matching fault bits. A separate program-load port writes words at any time.
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready/req_addr    : fetch request (byte address)
//   rsp_valid/rsp_ready             : response handshake
//   rsp_instr/rsp_fault             : fetched word, {range, misalign} flags
//   prog_we/prog_addr/prog_data     : program-load write (bad addresses dropped)
// LAT must be within 1..4; ADDR_W must be at most 32.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 32,
    parameter int                LAT      = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int IW = ADDR_W - 2;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH is representable even when it equals 2**IW.
    localparam logic [IW:0] DEPTH_X = (IW + 1)'(DEPTH);

    logic [IW-1:0] req_idx, prog_idx;
    logic [1:0]    req_fault;
    logic          prog_ok;
    logic          ready_en;
    logic          stall, advance, accept, rd_en, wr_en;
    logic [DATA_W-1:0] rd_data, last_data;
    fetch_stage_t  s1_d;
    fetch_stage_t  stg [LAT];

    // Address decode (full index width, unsigned)
    assign req_idx  = req_addr[ADDR_W-1:2];
    assign prog_idx = prog_addr[ADDR_W-1:2];

    assign req_fault[FAULT_MISALIGN] = |req_addr[1:0];
    assign req_fault[FAULT_RANGE]    = ({1'b0, req_idx} >= DEPTH_X);

    assign prog_ok = (prog_addr[1:0] == 2'b00) && ({1'b0, prog_idx} < DEPTH_X);

    // Handshake
    // req_ready stays low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign rsp_valid = stg[LAT-1].valid;
    assign stall     = rsp_valid & ~rsp_ready;
    assign advance   = ~stall;
    assign req_ready = ready_en & ~stall;
    assign accept    = req_valid & req_ready;

    // Out-of-range fetches never touch the array; the word is replaced anyway.
    assign rd_en = accept & ~req_fault[FAULT_RANGE];
    // rst_n gate drops a program write that lands on a reset edge.
    assign wr_en = prog_we & prog_ok & rst_n;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (prog_idx[AW-1:0]),
        .wdata (prog_data),
        .re    (rd_en),
        .raddr (req_idx[AW-1:0]),
        .rdata (rd_data)
    );

    // Stage control pipeline
    always_comb begin
        s1_d = '0;
        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.index = IDX_W'(req_idx);
            s1_d.fault = req_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else if (advance) begin
            stg[0] <= s1_d;
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
    end

    // Data pipeline: stage 1 is the array's read register, later stages copy.
    generate
        if (LAT == 1) begin : g_lat1
            assign last_data = rd_data;
        end else begin : g_latn
            logic [LAT-2:0][DATA_W-1:0] dq;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dq <= '0;
                end else if (advance) begin
                    dq[0] <= rd_data;
                    for (int i = 1; i < LAT - 1; i++) dq[i] <= dq[i-1];
                end
            end

            assign last_data = dq[LAT-2];
        end
    endgenerate

    // Output
    assign rsp_fault = stg[LAT-1].fault;
    assign rsp_instr = (|stg[LAT-1].fault) ? NOP_WORD : last_data;

endmodule
